spi_fifo_ext: RTL
=================

# spi_fifo_ext

Parametrised successor to the SPI controller's circular FIFO, used as the TX and RX data buffers between the register interface and the SPI shift engine. It keeps the show-ahead read port and adds several capabilities:
- correct wrap for any DEPTH, including non-power-of-two;
- simultaneous read/write when full;
- programmable almost-full and almost-empty thresholds;
- an occupancy level output;
- synchronous flush;
- optional sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, default `SPI_DATA_WIDTH`: word width, ≥1.
- DEPTH, default `SPI_FIFO_DEPTH`: number of entries, ≥2, any integer.
- AFULL_THR, default DEPTH-1: almost_full asserts when level ≥ AFULL_THR; range 1..DEPTH.
- AEMPTY_THR, default 1: almost_empty asserts when level ≤ AEMPTY_THR; range 0..DEPTH-1.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents.
- din  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request; pops the word currently on dout.
- dout  out  DATA_WIDTH  head word (show-ahead); 0 while empty.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AFULL_THR.
- almost_empty  out  1  level ≤ AEMPTY_THR.
- level  out  LVL_W = $clog2(DEPTH+1)  current occupancy.
- err_clr  in  1  clears sticky error flags.
- overflow  out  1  sticky: write rejected.
- underflow  out  1  sticky: read while empty.

## Operation
- State:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits (minimum 1), wrapping explicitly from DEPTH-1 to 0. Pointers never rely on natural binary overflow.
  - level register, LVL_W bits.
  - storage array of DEPTH × DATA_WIDTH.
- Accept rules:
  - Read is accepted when `rd_en && !empty`.
  - Write is accepted when `wr_en && (!full || rd_acc)`. When full, a simultaneous read frees the slot in the same cycle.
- Level update: +1 on write only, −1 on read only, unchanged on both or neither.
- When empty with `wr_en && rd_en`, only the write is accepted and level goes to 1. underflow sets if SPI_FIFO_ERR_EN is defined.
- Flush:
  - wr_ptr, rd_ptr and level go to 0. Storage is not cleared.
  - Flush has priority over wr_en and rd_en in the same cycle: neither is accepted and error flags do not set.
- Output flags are decoded combinationally from the registered level. dout is `mem[rd_ptr]` gated to 0 when empty.
- Reset values: level=0, empty=1, almost_empty=1, full=0, almost_full=0, dout=0, overflow=0, underflow=0.
- A reset asserted mid-burst discards all contents immediately.

## Timing
- Write accepted at edge N: level, flags and (if previously empty) dout are updated after edge N. Write-to-read latency is 1 cycle.
- Read at edge N: dout shows the next word after edge N. There is no read latency; dout is valid whenever empty=0.
- Flush at edge N: empty=1 after edge N.
- err_clr at edge N clears the flags after edge N. An error event in the same cycle as err_clr wins (flag remains set).
- No combinational path from wr_en, rd_en or flush to any output.

## Configuration
- SPI_FIFO_ERR_EN defined:
  - overflow sets on `wr_en && !flush && full && !rd_acc`.
  - underflow sets on `rd_en && !flush && empty`.
  - Both flags hold until err_clr.
- SPI_FIFO_ERR_EN undefined: overflow and underflow are tied to 0, err_clr is ignored, and no flag registers are synthesised. The port list is identical in both builds.

## Structure
- Shared package spi_pkg holds:
  - SPI_DATA_WIDTH and SPI_FIFO_DEPTH defaults;
  - a helper function for pointer increment-with-wrap;
  - LVL_W computation.
- Sub-module spi_fifo_ram: DEPTH × DATA_WIDTH storage with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr → rdata), no reset.
- The top level holds pointers, level, flags and error logic.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=5, AFULL_THR=4, AEMPTY_THR=1.
1. Reset then idle: empty=1, almost_empty=1, level=0, dout=0, full=0, overflow=0.
2. Write 0x11..0x55 over 5 cycles: level steps 1..5, almost_empty drops at level 2, almost_full rises at 4, full at 5. A 6th write of 0x66 is rejected, level stays 5, and overflow=1 (ERR_EN).
3. Non-power-of-two wrap:
   - Write 3 words, then read 3; then write 0xA0..0xA4.
   - Reads return 0xA0..0xA4 in order across the pointer wrap, ending with empty=1.
4. Full with simultaneous wr_en (0x77) and rd_en: dout advances, level stays 5, no overflow, and 0x77 is read out last.
5. Empty with simultaneous wr_en (0x5A) and rd_en: level=1, dout=0x5A next cycle, underflow=1. Then err_clr: underflow=0.
6. Level 3 with flush plus wr_en and rd_en in the same cycle: level=0, empty=1, no error set. Separately, asserting rst_n low mid-burst clears all outputs to their reset values asynchronously.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared defaults and helpers for the SPI FIFO blocks.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;
    localparam int SPI_FIFO_DEPTH = 8;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width: enough to address depth entries, never below 1 bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Pointer advance with explicit wrap at depth-1, valid for any depth.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/spi_fifo_ram.sv
// spi_fifo_ram: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read, no reset.
module spi_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port: store wdata at waddr on accepted writes.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/spi_fifo_ext.sv
// spi_fifo_ext: show-ahead circular FIFO with any-depth wrap, level output,
// almost-full/empty thresholds and synchronous flush.
// Optional sticky overflow/underflow flags are built when SPI_FIFO_ERR_EN is defined.
module spi_fifo_ext
    import spi_pkg::*;
#(
    parameter  int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter  int DEPTH      = SPI_FIFO_DEPTH,
    parameter  int AFULL_THR  = DEPTH - 1,
    parameter  int AEMPTY_THR = 1,
    localparam int LVL_W      = lvl_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [LVL_W-1:0]      level,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [PTR_W-1:0]      w_wr_ptr_nxt;
    logic [PTR_W-1:0]      w_rd_ptr_nxt;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_W'(DEPTH));

    // Flush blocks both ports; a read frees a full slot for a same-cycle write.
    assign w_rd_acc = rd_en && !w_empty && !flush;
    assign w_wr_acc = wr_en && (!w_full || w_rd_acc) && !flush;

    assign w_wr_ptr_nxt = PTR_W'(ptr_inc(int'(r_wr_ptr), DEPTH));
    assign w_rd_ptr_nxt = PTR_W'(ptr_inc(int'(r_rd_ptr), DEPTH));

    spi_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_acc),
        .waddr (r_wr_ptr),
        .wdata (din),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // Pointer and occupancy tracking; flush clears them but leaves storage intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign level        = r_level;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_level >= LVL_W'(AFULL_THR));
    assign almost_empty = (r_level <= LVL_W'(AEMPTY_THR));
    assign dout         = w_empty ? '0 : w_rdata;

`ifdef SPI_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;
    logic w_ovf_evt;
    logic w_unf_evt;

    assign w_ovf_evt = wr_en && !flush && w_full && !w_rd_acc;
    assign w_unf_evt = rd_en && !flush && w_empty;

    // Sticky error flags; a new event in the err_clr cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule
